// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM controlled sequencer that steps up to four patterns onto a PIO s1 write port,
// one strobe per programmed period, then parks the PIO at IDLE_VALUE and flags DONE/IRQ.
module pio_pattern_sequencer #(
  parameter int unsigned DATA_W     = 5,
  parameter int unsigned NUM_STEPS  = 4,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned IDLE_VALUE = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_PARK} state_t;

  localparam logic [1:0]        LAST_STEP = 2'(NUM_STEPS - 1);
  localparam logic [DATA_W-1:0] IDLE_VAL  = DATA_W'(IDLE_VALUE);

  state_t                state, next_state;
  logic [1:0]            step, next_step;
  logic [PERIOD_W-1:0]   period, cnt, eff_period;
  logic [DATA_W-1:0]     pattern [4];
  logic [DATA_W-1:0]     pio_data;
  logic                  run, loop, irq_en, done, set_done;
  logic                  wr, ctrl_wr, start, stop;
  logic                  unused_bits;

  assign wr         = chipselect & ~write_n;
  assign ctrl_wr    = wr && (address == 3'd0);
  assign start      = ctrl_wr && writedata[0] && !run && (state == S_IDLE);
  assign stop       = ctrl_wr && !writedata[0];
  assign eff_period = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign unused_bits = &{1'b0, writedata[31:PERIOD_W]};

  always_comb begin
    next_state = state;
    next_step  = step;
    set_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_WRITE;
          next_step  = 2'd0;
        end
      end
      S_WRITE: next_state = stop ? S_PARK : S_WAIT;
      S_WAIT: begin
        if (stop) begin
          next_state = S_PARK;
        end else if (cnt == '0) begin
          if (step != LAST_STEP) begin
            next_step  = step + 2'd1;
            next_state = S_WRITE;
          end else if (loop) begin
            next_step  = 2'd0;
            next_state = S_WRITE;
          end else begin
            set_done   = 1'b1;
            next_state = S_PARK;
          end
        end
      end
      S_PARK: begin
        next_state = S_IDLE;
        next_step  = 2'd0;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // PIO outputs are registered from the next state so the strobe lands in the same cycle
  // the FSM occupies WRITE/PARK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      step           <= 2'd0;
      cnt            <= '0;
      pio_chipselect <= 1'b0;
      pio_data       <= '0;
    end else begin
      state          <= next_state;
      step           <= next_step;
      pio_chipselect <= (next_state == S_WRITE) || (next_state == S_PARK);
      if (next_state == S_WRITE)
        pio_data <= pattern[next_step];
      else if (next_state == S_PARK)
        pio_data <= IDLE_VAL;
      if (state == S_WRITE)
        cnt <= eff_period - PERIOD_W'(2);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run    <= 1'b0;
      loop   <= 1'b0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      period <= '0;
      irq    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        pattern[i] <= IDLE_VAL;
    end else begin
      if (ctrl_wr) begin
        loop   <= writedata[1];
        irq_en <= writedata[2];
      end
      if (state == S_PARK)
        run <= 1'b0;
      else if (ctrl_wr)
        run <= writedata[0];
      if (wr && address == 3'd1)
        period <= writedata[PERIOD_W-1:0];
      if (set_done)
        done <= 1'b1;
      else if (wr && address == 3'd2 && writedata[0])
        done <= 1'b0;
      if (wr && address[2])
        pattern[address[1:0]] <= writedata[DATA_W-1:0];
      irq <= done & irq_en;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[5:0] = {step, (state != S_IDLE), irq_en, loop, run};
      3'd1: readdata[PERIOD_W-1:0] = period;
      3'd2: readdata[0] = done;
      3'd4, 3'd5, 3'd6, 3'd7: readdata[DATA_W-1:0] = pattern[address[1:0]];
      default: readdata = '0;
    endcase
  end

  assign pio_address   = 2'b00;
  assign pio_write_n   = ~pio_chipselect;
  assign pio_writedata = {{(32-DATA_W){1'b0}}, pio_data};

endmodule
